// File: rtl/piece_randomizer.sv
// ---------------------------------------------------------------------------
// piece_randomizer
//
// Picks the next falling piece (index 0..6) from a free-running 16-bit LFSR.
// A request draws a candidate from the high LFSR byte mixed with the spawn
// counter. A candidate of 7 or a repeat of the previous piece triggers one
// reroll. The reroll result is always accepted, even if it repeats.
//
// Ports
//   clk_in          : system clock, all state updates on posedge
//   rst_in          : synchronous active-high reset
//   rng_in[15:0]    : upstream LFSR value, may change every cycle
//   req_in          : single-cycle request for the next piece
//   piece_out[2:0]  : selected piece, held until the next selection
//   valid_out       : one-cycle pulse when piece_out has just been updated
//   busy_out        : high whenever the FSM is not idle
//   spawn_count_out : number of accepted requests, modulo 256
// ---------------------------------------------------------------------------
module piece_randomizer #(
    parameter logic [2:0] INIT_PREV = 3'd0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] rng_in,
    input  logic        req_in,
    output logic [2:0]  piece_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic [7:0]  spawn_count_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REROLL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cand_q, cand_d;
    logic [2:0]  prev_q, prev_d;
    logic [2:0]  piece_q, piece_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  count_inc;
    logic        valid_q, valid_d;
    logic        busy_q;
    logic [2:0]  reroll_piece;
    logic        rng_low_unused;

    // The low LFSR byte does not take part in piece selection.
    assign rng_low_unused = ^rng_in[7:0];

    // First-draw candidate: low three bits of (hi byte + incremented count),
    // summed in 8 bits so the carry chain matches the counter width.
    function automatic logic [2:0] first_draw(input logic [7:0] rng_hi,
                                              input logic [7:0] count);
        logic [7:0] sum;
        sum = rng_hi + count;
        return sum[2:0];
    endfunction

    // Reroll: (rnd + prev) folded into 0..6. The sum is at most 13, so a
    // single conditional subtraction of 7 is a full modulo-7 reduction.
    function automatic logic [2:0] fold_mod7(input logic [2:0] rnd,
                                             input logic [2:0] prev);
        logic [3:0] s;
        s = {1'b0, rnd} + {1'b0, prev};
        if (s >= 4'd7) begin
            s = s - 4'd7;
        end
        return s[2:0];
    endfunction

    // The reroll samples the live LFSR value, not the one seen at request time.
    assign reroll_piece = fold_mod7(rng_in[10:8], prev_q);

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        prev_d    = prev_q;
        piece_d   = piece_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        count_inc = count_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (req_in) begin
                    count_d = count_inc;
                    cand_d  = first_draw(rng_in[15:8], count_inc);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((cand_q != 3'd7) && (cand_q != prev_q)) begin
                    piece_d = cand_q;
                    prev_d  = cand_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = REROLL;
                end
            end
            REROLL: begin
                piece_d = reroll_piece;
                prev_d  = reroll_piece;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset overrides any selection in flight, so an aborted request never
    // pulses valid nor touches prev.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cand_q  <= 3'd0;
            prev_q  <= INIT_PREV;
            piece_q <= 3'd0;
            count_q <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            prev_q  <= prev_d;
            piece_q <= piece_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign piece_out       = piece_q;
    assign valid_out       = valid_q;
    assign busy_out        = busy_q;
    assign spawn_count_out = count_q;

endmodule

// File: tb/tb_piece_randomizer.sv
module tb_piece_randomizer;

    logic        clk_in;
    logic        rst_in;
    logic [15:0] rng_in;
    logic        req_in;
    logic [2:0]  piece_out;
    logic        valid_out;
    logic        busy_out;
    logic [7:0]  spawn_count_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] piece;
        logic [7:0] cnt;
        int         due;
    } exp_t;

    exp_t exp_q[$];

    piece_randomizer #(.INIT_PREV(3'd0)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rng_in          (rng_in),
        .req_in          (req_in),
        .piece_out       (piece_out),
        .valid_out       (valid_out),
        .busy_out        (busy_out),
        .spawn_count_out (spawn_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("piece", piece_out, e.piece);
                chk("count_at_valid", spawn_count_out, e.cnt);
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic do_reset();
        rst_in = 1'b1;
        req_in = 1'b1;        // must be ignored while in reset
        rng_in = 16'h0300;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        req_in = 1'b0;
        chk("rst_piece", piece_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_count", spawn_count_out, 0);
    endtask

    // Called #1 after a posedge; returns #1 after the edge that raises valid.
    task automatic request(input logic [15:0] r1, input logic [15:0] r2,
                           input logic [2:0] ep, input logic [7:0] ec,
                           input bit reroll, input bit spam);
        exp_t e;
        e.piece = ep;
        e.cnt   = ec;
        e.due   = cyc + (reroll ? 3 : 2);
        exp_q.push_back(e);
        rng_in = r1;
        req_in = 1'b1;
        @(posedge clk_in); #1;
        req_in = spam;
        rng_in = 16'hFFFF;
        chk("count_after_accept", spawn_count_out, ec);
        chk("busy_in_check", busy_out, 1);
        if (reroll) begin
            @(posedge clk_in); #1;
            rng_in = r2;
            req_in = spam;
            chk("busy_in_reroll", busy_out, 1);
        end
        @(posedge clk_in); #1;
        req_in = 1'b0;
        chk("count_after_done", spawn_count_out, ec);
        chk("busy_done", busy_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tgt;
        logic [7:0] hi;
        rst_in = 1'b1;
        req_in = 1'b0;
        rng_in = 16'h0000;

        // Reroll on 7: 6+1 = 7, reroll 5+0 = 5.
        do_reset();
        request(16'h0600, 16'h0500, 3'd5, 8'd1, 1'b1, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;

        // Direct accept: 3+1 = 4.
        do_reset();
        request(16'h0300, 16'h0000, 3'd4, 8'd1, 1'b0, 1'b0);
        @(posedge clk_in); #1;

        // Duplicate: 2+2 = 4 == prev, reroll (6+4)-7 = 3.
        request(16'h0200, 16'h0600, 3'd3, 8'd2, 1'b1, 1'b0);

        // Request in the valid cycle: 1+3 = 4, prev 3 -> direct.
        chk("valid_with_req", valid_out, 1);
        request(16'h0100, 16'h0000, 3'd4, 8'd3, 1'b0, 1'b0);
        @(posedge clk_in); #1;

        // Requests while busy are ignored; 0+4 = 4 == prev, reroll
        // (7+4)-7 = 4 accepted even though it repeats prev.
        request(16'h0000, 16'h0700, 3'd4, 8'd4, 1'b1, 1'b1);
        @(posedge clk_in); #1;
        chk("count_after_spam", spawn_count_out, 4);

        // Walk the counter to 255 with alternating targets, last one 0.
        for (int i = 5; i <= 255; i++) begin
            tgt = (i == 255) ? 8'd0 : ((i % 2) ? 8'd1 : 8'd2);
            hi  = tgt - 8'(i);
            request({hi, 8'h00}, 16'h0000, tgt[2:0], 8'(i), 1'b0, 1'b0);
        end
        @(posedge clk_in); #1;

        // Wrap: count 255 -> 0, cand 0 == prev 0 -> reroll 3+0 = 3.
        request(16'h0000, 16'h0300, 3'd3, 8'd0, 1'b1, 1'b0);
        @(posedge clk_in); #1;

        // Reset in REROLL: 2+1 = 3 == prev 3 -> reroll, then abort.
        rng_in = 16'h0200;
        req_in = 1'b1;
        @(posedge clk_in); #1;
        req_in = 1'b0;
        chk("abort_count", spawn_count_out, 1);
        @(posedge clk_in); #1;
        chk("abort_busy_reroll", busy_out, 1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("abort_piece", piece_out, 0);
        chk("abort_count_rst", spawn_count_out, 0);
        chk("abort_busy", busy_out, 0);
        chk("abort_valid", valid_out, 0);
        @(posedge clk_in); #1;
        chk("abort_valid_late", valid_out, 0);

        // prev back at 0: 2+1 = 3 accepted directly.
        request(16'h0200, 16'h0000, 3'd3, 8'd1, 1'b0, 1'b0);
        @(posedge clk_in); #1;

        // Reset in CHECK also aborts.
        rng_in = 16'h0000;
        req_in = 1'b1;
        @(posedge clk_in); #1;
        req_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("abort_chk_count", spawn_count_out, 0);
        chk("abort_chk_busy", busy_out, 0);
        chk("abort_chk_piece", piece_out, 0);

        repeat (10) @(posedge clk_in);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_randomizer.md
PIECE_RANDOMIZER -- requirements
Module: piece_randomizer

Interface
REQ-001 SHALL have parameter: INIT_PREV, default 3'd0, previous-piece value loaded on reset.
REQ-002 SHALL have port: clk_in  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port: rst_in  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rng_in  input  16  free-running output of the upstream 16-bit LFSR; it may change every cycle.
REQ-005 SHALL have port: req_in  input  1  single-cycle request for the next piece.
REQ-006 SHALL have port: piece_out  output  3  selected piece index, 0..6; held until the next selection.
REQ-007 SHALL have port: valid_out  output  1  one-cycle pulse when piece_out has just been updated.
REQ-008 SHALL have port: busy_out  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port: spawn_count_out  output  8  current spawn counter.

Function
REQ-010 SHALL implement the FSM states IDLE, CHECK and REROLL; all outputs SHALL be registered.
REQ-011 IDLE with req_in=1 at an edge SHALL do all of the following:
  - spawn_count <= spawn_count+1, wrapping modulo 256 (255 -> 0).
  - cand <= (rng_in[15:8] + (spawn_count+1))[2:0], all arithmetic 8-bit modulo 256.
  - state -> CHECK.
REQ-012 IDLE with req_in=0 SHALL hold all state; valid_out=0.
REQ-013 In CHECK, if cand != 7 and cand != prev, the FSM SHALL do all of the following:
  - piece_out <= cand and prev <= cand.
  - valid_out <= 1 for exactly the following cycle.
  - state -> IDLE.
REQ-014 In CHECK, if cand == 7 or cand == prev, the FSM SHALL move to REROLL with no output change.
REQ-015 In REROLL, the FSM SHALL sample rng_in freshly (not the value captured in IDLE) and do all of the following:
  - compute s = rng_in[10:8] + prev as a 4-bit value (range 0..13).
  - piece <= s - 7 if s >= 7, else s, giving a result in 0..6.
  - piece_out <= piece and prev <= piece.
  - valid_out <= 1 for one cycle; state -> IDLE.
REQ-016 A reroll result SHALL be accepted unconditionally, even when it equals prev; at most one reroll per request.
REQ-017 Latency from the req_in edge to valid_out high SHALL be 2 cycles without a reroll and 3 cycles with a reroll.
REQ-018 req_in asserted while busy_out=1 SHALL be ignored: no queuing, no counter change.
REQ-019 req_in in the same cycle that valid_out is high (FSM already in IDLE) SHALL be accepted normally.
REQ-020 piece_out SHALL never take the value 7.
REQ-021 spawn_count_out SHALL reflect the incremented count from the cycle after request acceptance onward.

Reset
REQ-022 rst_in=1 at an edge SHALL set all of the following, overriding any in-progress operation:
  - state = IDLE.
  - piece_out = 3'd0, prev = INIT_PREV, cand = 0.
  - spawn_count = 0, valid_out = 0, busy_out = 0.
REQ-023 Reset asserted in CHECK or REROLL SHALL abort the selection: no valid_out pulse, and prev is not updated by the aborted request.
REQ-024 req_in asserted in the same cycle as rst_in SHALL be ignored.

Verification
REQ-025 Direct accept: after reset (prev=0), req_in with rng_in=16'h0300 -> spawn_count_out=1, valid_out high 2 cycles later, piece_out=4.
REQ-026 Reroll on 7: after reset, req_in with rng_in=16'h0600 (6+1=7), then rng_in=16'h0500 during REROLL -> valid_out after 3 cycles, piece_out=5.
REQ-027 Reroll on duplicate: prev=4, spawn_count=1, req_in with rng_in=16'h0200 (2+2=4) -> REROLL with rng_in=16'h0600 gives (6+4)-7 -> piece_out=3.
REQ-028 Wrap-around: spawn_count=255, req_in with rng_in=16'h0000 -> spawn_count_out=0, cand=0; if prev=0 this takes the reroll path.
REQ-029 Busy and reset:
  - req_in pulses during CHECK/REROLL -> exactly one valid_out and one count increment.
  - rst_in asserted in REROLL -> no valid_out, piece_out=0, spawn_count_out=0.
